// File: rtl/bcd_convert_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (double-dabble, one bit per clock).
// Results are registered and held between conversions for an asynchronous display scanner.
module bcd_convert_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  value,
  input  logic        signed_mode,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd,
  output logic        negative,
  output logic [1:0]  blank
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state_q;
  logic [7:0]  bin_q;
  logic [11:0] scr_q;
  logic [2:0]  cnt_q;
  logic        sign_q;
  logic        busy_q;
  logic        done_q;
  logic [11:0] bcd_q;
  logic        neg_q;
  logic [1:0]  blank_q;

  logic [7:0]  mag_d;
  logic [7:0]  bin_d;
  logic [11:0] scr_d;
  logic [11:0] adj;
  logic [19:0] shifted;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // Two's-complement negate in 8 bits still yields 128 for 0x80, which fits unsigned.
  always_comb begin
    mag_d = (signed_mode && value[7]) ? (~value + 8'd1) : value;
  end

  always_comb begin
    adj     = {add3(scr_q[11:8]), add3(scr_q[7:4]), add3(scr_q[3:0])};
    shifted = {adj[10:0], bin_q, 1'b0};
    scr_d   = shifted[19:8];
    bin_d   = shifted[7:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      bin_q   <= 8'd0;
      scr_q   <= 12'd0;
      cnt_q   <= 3'd0;
      sign_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= 12'h000;
      neg_q   <= 1'b0;
      blank_q <= 2'b11;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SHIFT;
            busy_q  <= 1'b1;
            bin_q   <= mag_d;
            scr_q   <= 12'd0;
            cnt_q   <= 3'd0;
            sign_q  <= signed_mode & value[7];
          end
        end
        SHIFT: begin
          bin_q <= bin_d;
          scr_q <= scr_d;
          cnt_q <= cnt_q + 3'd1;
          // Last shift: publish the post-shift scratch directly, never the intermediate.
          if (cnt_q == 3'd7) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            bcd_q   <= scr_d;
            neg_q   <= sign_q;
            blank_q <= {(scr_d[11:8] == 4'd0),
                        (scr_d[11:8] == 4'd0) && (scr_d[7:4] == 4'd0)};
          end
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign negative = neg_q;
  assign blank    = blank_q;

endmodule

// File: doc/bcd_convert_seq.md
# bcd_convert_seq

Sequential binary-to-BCD converter that sits directly downstream of the 8-bit ALU result register. It accepts an 8-bit result value (unsigned or two's-complement) on a start strobe and runs a shift-and-add-3 (double-dabble) conversion over 8 clocks. It then presents three registered BCD digits, a sign flag and leading-zero blanking flags to the seven-segment decoder. Outputs hold stable between conversions, so the display scanner can read them asynchronously to ALU activity.

## Interface
- No parameters; data width is fixed at 8 bits and output width at 3 BCD digits.
- clock  input  1  rising-edge system clock
- reset  input  1  asynchronous, active-high; clears all state and outputs
- start  input  1  conversion request; sampled only in IDLE
- value  input  8  binary value to convert; sampled with start
- signed_mode  input  1  1 = value is two's complement, 0 = unsigned; sampled with start
- busy  output  1  high while a conversion is in progress
- done  output  1  single-cycle pulse when new results are written
- bcd  output  12  {hundreds[11:8], tens[7:4], ones[3:0]}, each 0–9
- negative  output  1  sign of the last converted value (signed_mode only)
- blank  output  2  blank[1] = hundreds digit is a leading zero; blank[0] = tens digit is a leading zero

## Operation
- FSM states: IDLE, SHIFT.
- Transitions:
  - IDLE → SHIFT on start = 1.
  - SHIFT → IDLE after the 8th shift.
- Load, on the start edge in IDLE:
  - Magnitude: value if signed_mode = 0 or value[7] = 0; otherwise (~value + 1) taken as a 9-bit result, so 0x80 gives 128.
  - The magnitude goes into the binary shift register.
  - Scratch BCD (12 bits) is cleared.
  - Shift counter is set to 0.
  - Pending sign = signed_mode & value[7].
- SHIFT, each edge:
  - Every scratch digit ≥ 5 gets +3, in parallel.
  - Then {scratch, shiftreg} shifts left by 1.
  - The counter increments.
- Completion, on the 8th SHIFT edge (counter = 7):
  - bcd, negative and blank load from the final scratch value and pending sign.
  - done = 1 and state goes to IDLE.
- blank rules:
  - blank[1] = (hundreds == 0).
  - blank[0] = (hundreds == 0) & (tens == 0).
  - The ones digit is never blanked.
- Held outputs: bcd, negative and blank change only at completion or reset. Scratch state is never visible on them.
- start while busy is ignored; changes to value and signed_mode mid-conversion are ignored.
- negative = 0 whenever signed_mode was 0 at start.
- A magnitude of 0 gives bcd = 0x000, negative = 0 (signed 0 is not negative) and blank = 2'b11.

## Timing
- Reset values: busy = 0, done = 0, bcd = 12'h000, negative = 0, blank = 2'b11, state = IDLE, counter = 0.
- Start sampled at edge k:
  - busy is 1 from edge k through edge k+8, and falls at edge k+8.
  - done is 1 for exactly the cycle following edge k+8.
  - New bcd, negative and blank are valid from edge k+8.
- Latency is 8 clocks from the start edge to the result.
- The earliest next start is sampled at edge k+9. A start held high during the done cycle is accepted, so back-to-back throughput is one conversion per 9 clocks.
- Holding start continuously re-launches a conversion each time the FSM returns to IDLE.
- Reset mid-conversion:
  - Immediate abort with no done pulse.
  - All outputs return to reset values.
  - start must be re-asserted after reset deasserts.
- Reset and start on the same edge: reset wins and the conversion is not launched.

## Test plan
- Unsigned 255:
  - Stimulus: reset, then start for 1 cycle with value = 0xFF, signed_mode = 0.
  - Response: busy for 8 cycles; done pulse at edge +8; bcd = 0x255, negative = 0, blank = 2'b00.
- Signed minimum:
  - Stimulus: value = 0x80, signed_mode = 1.
  - Response: bcd = 0x128, negative = 1, blank = 2'b00.
- Signed −1 and unsigned 7:
  - value = 0xFF, signed_mode = 1 → bcd = 0x001, negative = 1, blank = 2'b11.
  - value = 0x07, signed_mode = 0 → bcd = 0x007, negative = 0, blank = 2'b11.
  - value = 0x2A, signed_mode = 0 → bcd = 0x042, blank = 2'b10.
- Start during busy:
  - Stimulus: start 0x64 (unsigned), then pulse start with 0x09 at edge +3 and change value mid-run.
  - Response: one done only; bcd = 0x100, blank = 2'b00; then a start held in the done cycle converts 0x09 → bcd = 0x009, with done 9 cycles after the first done.
- Reset mid-conversion:
  - Stimulus: after a completed 0xC8 → 0x200 result, start 0x63, then assert reset at edge +4.
  - Response: busy = 0, bcd = 0x000, blank = 2'b11, and no done pulse.
  - Then start 0x63 again → bcd = 0x099.
- Exhaustive sweep: all 256 values × both signed_mode settings; each bcd, negative and blank matches a reference model, and each conversion produces exactly one done.
